// File: rtl/ram_tdp_be.sv
// True dual-port byte-enabled word RAM with selectable read-during-write behaviour,
// 1- or 2-cycle read latency, read-valid strobes and a fill engine for init and clear.
module ram_tdp_be #(
    parameter int               WIDTH         = 64,
    parameter int               DEPTH         = 2048,
    parameter int               ADDR_BITS     = 11,
    parameter int               BYTE_W        = 8,
    parameter int               RDW_MODE      = 0,
    parameter int               READ_LATENCY  = 1,
    parameter int               INIT_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    input  logic [WIDTH-1:0]           clr_value,
    output logic                       busy,
    input  logic                       en_a,
    input  logic                       we_a,
    input  logic [WIDTH/BYTE_W-1:0]    be_a,
    input  logic [ADDR_BITS-1:0]       addr_a,
    input  logic [WIDTH-1:0]           wdata_a,
    output logic [WIDTH-1:0]           rdata_a,
    output logic                       rvalid_a,
    input  logic                       en_b,
    input  logic                       we_b,
    input  logic [WIDTH/BYTE_W-1:0]    be_b,
    input  logic [ADDR_BITS-1:0]       addr_b,
    input  logic [WIDTH-1:0]           wdata_b,
    output logic [WIDTH-1:0]           rdata_b,
    output logic                       rvalid_b
);
    localparam int NBE    = WIDTH / BYTE_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] IDX_LAST = MEM_AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_CLEAR} state_t;

    state_t              r_state;
    logic                r_busy;
    logic [MEM_AW-1:0]   r_idx;
    logic [WIDTH-1:0]    r_fill_value;

    logic                w_acc_a, w_acc_b;
    logic                w_inr_a, w_inr_b;
    logic                w_same_ab;
    logic                w_fill_we;
    logic [MEM_AW-1:0]   w_idx_a, w_idx_b;
    logic [WIDTH-1:0]    w_rd1_a, w_rd1_b;
    logic                r_v1_a, r_v1_b;

    // Fill engine: one full word per cycle; busy falls on the edge writing the last index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
            r_busy       <= (INIT_ON_RESET != 0);
            r_idx        <= '0;
            r_fill_value <= INIT_VALUE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state      <= S_CLEAR;
                        r_busy       <= 1'b1;
                        r_idx        <= '0;
                        r_fill_value <= clr_value;
                    end
                end
                S_INIT, S_CLEAR: begin
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + MEM_AW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign w_acc_a   = en_a & ~r_busy & ~rst;
    assign w_acc_b   = en_b & ~r_busy & ~rst;
    assign w_fill_we = r_busy & ~rst;
    assign w_same_ab = (addr_a == addr_b);
    assign w_idx_a   = addr_a[MEM_AW-1:0];
    assign w_idx_b   = addr_b[MEM_AW-1:0];

    // Range check only exists when the address bus can reach past the last word.
    if (DEPTH < (2 ** ADDR_BITS)) begin : g_range
        localparam logic [ADDR_BITS:0] DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH);
        assign w_inr_a = ({1'b0, addr_a} < DEPTH_LIM);
        assign w_inr_b = ({1'b0, addr_b} < DEPTH_LIM);
    end else begin : g_full
        assign w_inr_a = 1'b1;
        assign w_inr_b = 1'b1;
    end

    for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
        logic [BYTE_W-1:0] r_mem [DEPTH];
        logic [BYTE_W-1:0] r_q_a, r_q_b;
        logic [BYTE_W-1:0] w_wd_a, w_wd_b, w_fill;
        logic              w_wr_a, w_wr_b;

        assign w_wd_a = wdata_a[gi*BYTE_W +: BYTE_W];
        assign w_wd_b = wdata_b[gi*BYTE_W +: BYTE_W];
        assign w_fill = r_fill_value[gi*BYTE_W +: BYTE_W];
        assign w_wr_a = w_acc_a & we_a & be_a[gi] & w_inr_a;
        assign w_wr_b = w_acc_b & we_b & be_b[gi] & w_inr_b;

        // Port A is written last so it owns any lane both ports hit at the same address.
        always_ff @(posedge clk) begin
            if (w_fill_we) begin
                r_mem[r_idx] <= w_fill;
            end else begin
                if (w_wr_b) r_mem[w_idx_b] <= w_wd_b;
                if (w_wr_a) r_mem[w_idx_a] <= w_wd_a;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q_a <= '0;
                r_q_b <= '0;
            end else begin
                if (w_acc_a) begin
                    if (!w_inr_a)                              r_q_a <= '0;
                    else if (RDW_MODE == 1 && w_wr_a)              r_q_a <= w_wd_a;
                    else if (RDW_MODE == 1 && w_wr_b && w_same_ab) r_q_a <= w_wd_b;
                    else                                           r_q_a <= r_mem[w_idx_a];
                end
                if (w_acc_b) begin
                    if (!w_inr_b)                              r_q_b <= '0;
                    else if (RDW_MODE == 1 && w_wr_a && w_same_ab) r_q_b <= w_wd_a;
                    else if (RDW_MODE == 1 && w_wr_b)              r_q_b <= w_wd_b;
                    else                                           r_q_b <= r_mem[w_idx_b];
                end
            end
        end

        assign w_rd1_a[gi*BYTE_W +: BYTE_W] = r_q_a;
        assign w_rd1_b[gi*BYTE_W +: BYTE_W] = r_q_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
        end else begin
            r_v1_a <= w_acc_a;
            r_v1_b <= w_acc_b;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [WIDTH-1:0] r_d2_a, r_d2_b;
        logic             r_v2_a, r_v2_b;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_d2_a <= '0;
                r_d2_b <= '0;
                r_v2_a <= 1'b0;
                r_v2_b <= 1'b0;
            end else begin
                r_v2_a <= r_v1_a;
                r_v2_b <= r_v1_b;
                if (r_v1_a) r_d2_a <= w_rd1_a;
                if (r_v1_b) r_d2_b <= w_rd1_b;
            end
        end

        assign rdata_a  = r_d2_a;
        assign rdata_b  = r_d2_b;
        assign rvalid_a = r_v2_a;
        assign rvalid_b = r_v2_b;
    end else begin : g_lat1
        assign rdata_a  = w_rd1_a;
        assign rdata_b  = w_rd1_b;
        assign rvalid_a = r_v1_a;
        assign rvalid_b = r_v1_b;
    end
endmodule

// File: tb/tb_ram_tdp_be.sv
// Bench for ram_tdp_be: two instances (READ_FIRST/latency 1/depth 16 and
// WRITE_FIRST/latency 2/depth 12) share one stimulus stream and one word-level model.
module tb_ram_tdp_be;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr_req;
    logic [63:0] clr_value;
    logic        en_a, we_a, en_b, we_b;
    logic [7:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [63:0] wdata_a, wdata_b;

    logic        busy0, busy1, rva0, rvb0, rva1, rvb1;
    logic [63:0] rda0, rdb0, rda1, rdb1;

    ram_tdp_be #(.WIDTH(64), .DEPTH(16), .ADDR_BITS(4), .BYTE_W(8), .RDW_MODE(0),
                 .READ_LATENCY(1), .INIT_ON_RESET(1), .INIT_VALUE({64{1'b1}})) dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_value(clr_value), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rda0), .rvalid_a(rva0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdb0), .rvalid_b(rvb0));

    ram_tdp_be #(.WIDTH(64), .DEPTH(12), .ADDR_BITS(4), .BYTE_W(8), .RDW_MODE(1),
                 .READ_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE({64{1'b1}})) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_value(clr_value), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rda1), .rvalid_a(rva1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdb1), .rvalid_b(rvb1));

    logic        o_busy [2];
    logic        o_v [2][2];
    logic [63:0] o_d [2][2];
    assign o_busy[0] = busy0;  assign o_busy[1] = busy1;
    assign o_v[0][0] = rva0;   assign o_v[0][1] = rvb0;
    assign o_v[1][0] = rva1;   assign o_v[1][1] = rvb1;
    assign o_d[0][0] = rda0;   assign o_d[0][1] = rdb0;
    assign o_d[1][0] = rda1;   assign o_d[1][1] = rdb1;

    // Word-level model: memory image, fill countdown, and delay lines of read results.
    logic [63:0] m_mem [2][16];
    int          m_left [2];
    int          m_idx [2];
    logic [63:0] m_fval [2];
    logic        m_hv [2][2][2];
    logic [63:0] m_hd [2][2][2];
    logic        e_v [2][2];
    logic [63:0] e_d [2][2];
    logic        e_busy [2];

    int total = 0;
    int bad   = 0;

    task automatic idle();
        en_a = 0; we_a = 0; be_a = 0; addr_a = 0; wdata_a = 0;
        en_b = 0; we_b = 0; be_b = 0; addr_b = 0; wdata_b = 0;
        clr_req = 0; clr_value = 0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUTs.
    task automatic tick();
        logic [63:0] oldm [16];
        logic        acc [2];
        logic        env [2], wev [2];
        logic [3:0]  ad [2];
        logic [7:0]  bev [2];
        logic [63:0] wd [2];
        logic [63:0] rv [2];
        int          dep, lat;
        bit          busy_pre;
        env[0] = en_a; wev[0] = we_a; ad[0] = addr_a; bev[0] = be_a; wd[0] = wdata_a;
        env[1] = en_b; wev[1] = we_b; ad[1] = addr_b; bev[1] = be_b; wd[1] = wdata_b;
        for (int d = 0; d < 2; d++) begin
            dep = (d == 0) ? 16 : 12;
            lat = (d == 0) ? 1 : 2;
            busy_pre = (m_left[d] > 0);
            if (rst) begin
                m_left[d] = dep; m_idx[d] = 0; m_fval[d] = '1;
                for (int p = 0; p < 2; p++) begin
                    m_hv[d][p][0] = 0; m_hv[d][p][1] = 0;
                    m_hd[d][p][0] = 0; m_hd[d][p][1] = 0;
                    e_v[d][p] = 0; e_d[d][p] = 0;
                end
            end else begin
                oldm = m_mem[d];
                for (int p = 0; p < 2; p++) acc[p] = env[p] && !busy_pre;
                // B applied first, then A: A owns contested lanes
                for (int p = 1; p >= 0; p--) begin
                    if (acc[p] && wev[p] && int'(ad[p]) < dep)
                        for (int l = 0; l < 8; l++)
                            if (bev[p][l]) m_mem[d][ad[p]][l*8 +: 8] = wd[p][l*8 +: 8];
                end
                for (int p = 0; p < 2; p++) begin
                    if (int'(ad[p]) >= dep) rv[p] = '0;
                    else if (d == 1)        rv[p] = m_mem[d][ad[p]];
                    else                    rv[p] = oldm[ad[p]];
                    if (d == 0 && acc[p])
                        $display("txn t=%0t port=%0d addr=%0d we=%0b be=%02h wdata=%h read=%h",
                                 $time, p, ad[p], wev[p], bev[p], wd[p], rv[p]);
                end
                if (busy_pre) begin
                    m_mem[d][m_idx[d]] = m_fval[d];
                    m_idx[d]++;
                    m_left[d]--;
                end else if (clr_req) begin
                    m_left[d] = dep; m_idx[d] = 0; m_fval[d] = clr_value;
                end
                for (int p = 0; p < 2; p++) begin
                    m_hv[d][p][1] = m_hv[d][p][0]; m_hv[d][p][0] = acc[p];
                    m_hd[d][p][1] = m_hd[d][p][0]; m_hd[d][p][0] = rv[p];
                    e_v[d][p] = m_hv[d][p][lat-1];
                    if (e_v[d][p]) e_d[d][p] = m_hd[d][p][lat-1];
                end
            end
            e_busy[d] = (m_left[d] > 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_cnt;
        idle();
        rst = 1;
        tick();
        tick();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL reset_busy got=%0b exp=1", busy0); end
        total++; if (rva0 !== 1'b0 || rda0 !== 64'd0) begin bad++; $display("FAIL reset_rd got v=%0b d=%h exp v=0 d=0", rva0, rda0); end
        rst = 0;
        busy_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (busy0) busy_cnt++;
            for (int d = 0; d < 2; d++) begin
                total++; if (o_busy[d] !== e_busy[d]) begin bad++; $display("FAIL init_busy dut%0d cyc=%0d got=%0b exp=%0b", d, c, o_busy[d], e_busy[d]); end
            end
        end
        // busy seen high at the reset edge plus 15 more edges = 16 cycles total
        total++; if (busy_cnt !== 15) begin bad++; $display("FAIL init_len got=%0d exp=15", busy_cnt); end
        for (int a = 0; a < 16; a++) begin
            en_a = 1; addr_a = 4'(a);
            tick();
            total++; if (rva0 !== 1'b1 || rda0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL init_read addr=%0d got v=%0b d=%h exp v=1 d=ffffffffffffffff", a, rva0, rda0); end
            for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
                total++; if (o_v[d][p] !== e_v[d][p] || o_d[d][p] !== e_d[d][p]) begin bad++; $display("FAIL init_rd dut%0d p%0d got v=%0b d=%h exp v=%0b d=%h", d, p, o_v[d][p], o_d[d][p], e_v[d][p], e_d[d][p]); end
            end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_byte_enable();
        idle();
        en_a = 1; we_a = 1; addr_a = 3; be_a = 8'h0F; wdata_a = 64'h1122334455667788;
        tick();
        idle();
        en_a = 1; addr_a = 3;
        tick();
        total++; if (rda0 !== 64'hFFFFFFFF55667788) begin bad++; $display("FAIL byte_en got=%h exp=ffffffff55667788", rda0); end
        idle();
        tick();
        total++; if (rva1 !== 1'b1 || rda1 !== 64'hFFFFFFFF55667788) begin bad++; $display("FAIL byte_en_l2 got v=%0b d=%h exp v=1 d=ffffffff55667788", rva1, rda1); end
    endtask

    task automatic test_cross_write();
        idle();
        en_a = 1; we_a = 1; addr_a = 5; be_a = 8'h0F; wdata_a = 64'hAAAAAAAAAAAAAAAA;
        en_b = 1; we_b = 1; addr_b = 5; be_b = 8'hFF; wdata_b = 64'hBBBBBBBBBBBBBBBB;
        tick();
        idle();
        en_a = 1; addr_a = 5;
        tick();
        total++; if (rda0 !== 64'hBBBBBBBBAAAAAAAA) begin bad++; $display("FAIL cross_write got=%h exp=bbbbbbbbaaaaaaaa", rda0); end
        idle();
        tick();
        total++; if (rda1 !== 64'hBBBBBBBBAAAAAAAA) begin bad++; $display("FAIL cross_write_l2 got=%h exp=bbbbbbbbaaaaaaaa", rda1); end
    endtask

    task automatic test_rdw();
        idle();
        en_a = 1; we_a = 1; addr_a = 7; be_a = 8'hFF; wdata_a = 64'h9;
        tick();
        en_a = 1; we_a = 1; addr_a = 7; be_a = 8'hFF; wdata_a = 64'h5;
        en_b = 1; we_b = 0; addr_b = 7;
        tick();
        total++; if (rvb0 !== 1'b1 || rdb0 !== 64'h9) begin bad++; $display("FAIL rdw_read_first got v=%0b d=%h exp v=1 d=9", rvb0, rdb0); end
        idle();
        tick();
        total++; if (rvb1 !== 1'b1 || rdb1 !== 64'h5) begin bad++; $display("FAIL rdw_write_first got v=%0b d=%h exp v=1 d=5", rvb1, rdb1); end
        total++; if (rvb0 !== 1'b0 || rdb0 !== 64'h9) begin bad++; $display("FAIL rdw_hold got v=%0b d=%h exp v=0 d=9", rvb0, rdb0); end
    endtask

    task automatic test_latency2();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 3) begin en_a = 1; addr_a = 4'(c); end
            tick();
            if (rva1) pulses++;
            total++; if (rva1 !== ((c >= 1) && (c <= 3))) begin bad++; $display("FAIL lat2_valid cyc=%0d got=%0b", c, rva1); end
            for (int d = 0; d < 2; d++) begin
                total++; if (o_v[d][0] !== e_v[d][0] || o_d[d][0] !== e_d[d][0]) begin bad++; $display("FAIL lat2_rd dut%0d got v=%0b d=%h exp v=%0b d=%h", d, o_v[d][0], o_d[d][0], e_v[d][0], e_d[d][0]); end
            end
        end
        total++; if (pulses !== 3) begin bad++; $display("FAIL lat2_pulses got=%0d exp=3", pulses); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            en_a = 1'($urandom); we_a = 1'($urandom); be_a = 8'($urandom);
            addr_a = 4'($urandom); wdata_a = {$urandom, $urandom};
            en_b = 1'($urandom); we_b = 1'($urandom); be_b = 8'($urandom);
            addr_b = ($urandom_range(0, 2) == 0) ? addr_a : 4'($urandom);
            wdata_b = {$urandom, $urandom};
            clr_req = ($urandom_range(0, 79) == 0);
            clr_value = {$urandom, $urandom};
            tick();
            for (int d = 0; d < 2; d++) begin
                total++; if (o_busy[d] !== e_busy[d]) begin bad++; $display("FAIL rnd_busy dut%0d cyc=%0d got=%0b exp=%0b", d, c, o_busy[d], e_busy[d]); end
                for (int p = 0; p < 2; p++) begin
                    total++; if (o_v[d][p] !== e_v[d][p] || o_d[d][p] !== e_d[d][p]) begin bad++; $display("FAIL rnd_rd dut%0d p%0d cyc=%0d got v=%0b d=%h exp v=%0b d=%h", d, p, c, o_v[d][p], o_d[d][p], e_v[d][p], e_d[d][p]); end
                end
            end
        end
        idle();
        for (int c = 0; c < 20; c++) tick();
    endtask

    task automatic test_clear();
        idle();
        en_a = 1; addr_a = 2; clr_req = 1; clr_value = 64'd0;
        tick();
        for (int c = 0; c < 8; c++) begin
            en_a = 1; we_a = 1; be_a = 8'hFF; addr_a = 4'(c + 8); wdata_a = {$urandom, $urandom};
            en_b = 1; addr_b = 4'(c); clr_req = 1'($urandom);
            tick();
            total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL clr_busy cyc=%0d got=%0b exp=1", c, busy0); end
            for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
                total++; if (o_v[d][p] !== e_v[d][p] || o_d[d][p] !== e_d[d][p]) begin bad++; $display("FAIL clr_rd dut%0d p%0d got v=%0b d=%h exp v=%0b d=%h", d, p, o_v[d][p], o_d[d][p], e_v[d][p], e_d[d][p]); end
            end
        end
        total++; if (rvb0 !== 1'b0) begin bad++; $display("FAIL clr_ignored got rvalid=%0b exp=0", rvb0); end
        idle();
        rst = 1;
        tick();
        rst = 0;
        for (int c = 0; c < 16; c++) tick();
        for (int a = 0; a < 17; a++) begin
            idle();
            if (a < 16) begin en_a = 1; addr_a = 4'(a); en_b = 1; addr_b = 4'(15 - a); end
            tick();
            if (a < 16) begin
                total++; if (rda0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL reinit addr=%0d got=%h exp=ffffffffffffffff", a, rda0); end
            end
            for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
                total++; if (o_v[d][p] !== e_v[d][p] || o_d[d][p] !== e_d[d][p]) begin bad++; $display("FAIL reinit_rd dut%0d p%0d got v=%0b d=%h exp v=%0b d=%h", d, p, o_v[d][p], o_d[d][p], e_v[d][p], e_d[d][p]); end
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        for (int d = 0; d < 2; d++) m_left[d] = 0;
        test_reset();
        test_byte_enable();
        test_cross_write();
        test_rdw();
        test_latency2();
        test_back_to_back();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
